// File: rtl/freq_compare_ctrl_if.sv
// Frequency-compare handshake bundle between the reference-domain controller
// and its environment (enable/result side plus the synchronized
// measured-domain counter signals). The margin field exists only when
// FREQ_COMPARE_MARGIN_EN is defined.
interface freq_compare_ctrl_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  enable;
   logic [DATA_WIDTH-1:0] timeout_value;
   logic                  timer_done;
   logic [DATA_WIDTH-1:0] timeout_compare;
`ifdef FREQ_COMPARE_MARGIN_EN
   logic [DATA_WIDTH-1:0] margin;
`endif
   logic                  count_enable;
   logic [DATA_WIDTH-1:0] timeout_count;
   logic                  compare_ge;
   logic                  compare_done;
   logic                  compare_err;

`ifdef FREQ_COMPARE_MARGIN_EN
   modport master (
      output enable, timeout_value, timer_done, timeout_compare, margin,
      input  count_enable, timeout_count, compare_ge, compare_done, compare_err
   );
   modport slave (
      input  enable, timeout_value, timer_done, timeout_compare, margin,
      output count_enable, timeout_count, compare_ge, compare_done, compare_err
   );
`else
   modport master (
      output enable, timeout_value, timer_done, timeout_compare,
      input  count_enable, timeout_count, compare_ge, compare_done, compare_err
   );
   modport slave (
      input  enable, timeout_value, timer_done, timeout_compare,
      output count_enable, timeout_count, compare_ge, compare_done, compare_err
   );
`endif
endinterface

// File: rtl/freq_compare_ctrl.sv
// freq_compare_ctrl: reference-domain initiator of the frequency-compare
// handshake. Opens a count_enable window of at least timeout_value cycles,
// waits for the measured-domain timer_done, then compares the measured count
// against the window length. A watchdog bounds the wait for timer_done.
// Optional feature: define FREQ_COMPARE_MARGIN_EN to add a margin term that
// is added to the measured count before comparing.
module freq_compare_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int WAIT_LIMIT = 64
) (
   input logic               clk,
   input logic               reset_n,
   freq_compare_ctrl_if.slave bus
);

   localparam int WAIT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COUNT,
      ST_WAIT_DONE,
      ST_COMPARE,
      ST_DONE
   } state_t;

   state_t                state_reg, state_next;
   logic                  enable_d_reg;
   logic [DATA_WIDTH-1:0] value_reg, value_next;
   logic [DATA_WIDTH-1:0] count_reg, count_next;
   logic                  clr_seen_reg, clr_seen_next;
   logic [WAIT_W-1:0]     wait_cnt_reg, wait_cnt_next;
   logic                  count_enable_reg, count_enable_next;
   logic                  compare_ge_reg, compare_ge_next;
   logic                  compare_done_reg, compare_done_next;
   logic                  compare_err_reg, compare_err_next;
`ifdef FREQ_COMPARE_MARGIN_EN
   logic [DATA_WIDTH-1:0] margin_reg, margin_next;
`endif

   logic                  start;
   logic                  abort;
   logic [DATA_WIDTH:0]   count_inc;
   logic [DATA_WIDTH-1:0] count_sat;
   logic                  window_full;
   logic                  ge_result;

   assign start       = bus.enable & ~enable_d_reg;
   assign abort       = ~bus.enable;
   // One extra bit so the increment and the window test never wrap.
   assign count_inc   = {1'b0, count_reg} + {{DATA_WIDTH{1'b0}}, 1'b1};
   assign count_sat   = count_inc[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : count_inc[DATA_WIDTH-1:0];
   assign window_full = count_inc >= {1'b0, value_reg};

`ifdef FREQ_COMPARE_MARGIN_EN
   assign ge_result = ({1'b0, bus.timeout_compare} + {1'b0, margin_reg}) >= {1'b0, count_reg};
`else
   assign ge_result = {1'b0, bus.timeout_compare} >= {1'b0, count_reg};
`endif

   // State register and all registered outputs; reset clears everything.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg        <= ST_IDLE;
         enable_d_reg     <= 1'b0;
         value_reg        <= '0;
         count_reg        <= '0;
         clr_seen_reg     <= 1'b0;
         wait_cnt_reg     <= '0;
         count_enable_reg <= 1'b0;
         compare_ge_reg   <= 1'b0;
         compare_done_reg <= 1'b0;
         compare_err_reg  <= 1'b0;
`ifdef FREQ_COMPARE_MARGIN_EN
         margin_reg       <= '0;
`endif
      end else begin
         state_reg        <= state_next;
         enable_d_reg     <= bus.enable;
         value_reg        <= value_next;
         count_reg        <= count_next;
         clr_seen_reg     <= clr_seen_next;
         wait_cnt_reg     <= wait_cnt_next;
         count_enable_reg <= count_enable_next;
         compare_ge_reg   <= compare_ge_next;
         compare_done_reg <= compare_done_next;
         compare_err_reg  <= compare_err_next;
`ifdef FREQ_COMPARE_MARGIN_EN
         margin_reg       <= margin_next;
`endif
      end
   end

   // Next-state and datapath decisions; abort has priority in every busy state.
   always_comb begin
      state_next       = state_reg;
      value_next       = value_reg;
      count_next       = count_reg;
      clr_seen_next    = clr_seen_reg;
      wait_cnt_next    = wait_cnt_reg;
      compare_ge_next  = compare_ge_reg;
      compare_err_next = compare_err_reg;
`ifdef FREQ_COMPARE_MARGIN_EN
      margin_next      = margin_reg;
`endif

      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               count_next      = '0;
               compare_ge_next = 1'b0;
               if (bus.timeout_value == '0) begin
                  // A zero-length window cannot be measured.
                  state_next       = ST_DONE;
                  compare_err_next = 1'b1;
               end else begin
                  state_next    = ST_COUNT;
                  value_next    = bus.timeout_value;
                  clr_seen_next = 1'b0;
`ifdef FREQ_COMPARE_MARGIN_EN
                  margin_next   = bus.margin;
`endif
               end
            end
         end

         ST_COUNT: begin
            if (abort) begin
               state_next = ST_IDLE;
            end else begin
               count_next = count_sat;
               if (!bus.timer_done) begin
                  clr_seen_next = 1'b1;
               end
               // Keep the window open while a done from the previous run is still high.
               if (window_full && (clr_seen_reg || !bus.timer_done)) begin
                  state_next    = ST_WAIT_DONE;
                  wait_cnt_next = '0;
               end
            end
         end

         ST_WAIT_DONE: begin
            if (abort) begin
               state_next = ST_IDLE;
            end else if (bus.timer_done) begin
               state_next = ST_COMPARE;
            end else if (wait_cnt_reg == WAIT_W'(WAIT_LIMIT - 1)) begin
               state_next       = ST_DONE;
               compare_err_next = 1'b1;
               compare_ge_next  = 1'b0;
            end else begin
               wait_cnt_next = wait_cnt_reg + 1'b1;
            end
         end

         ST_COMPARE: begin
            if (abort) begin
               state_next = ST_IDLE;
            end else begin
               compare_ge_next = ge_result;
               state_next      = ST_DONE;
            end
         end

         ST_DONE: begin
            if (!bus.enable) begin
               state_next       = ST_IDLE;
               compare_err_next = 1'b0;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // Window and done flags are registered decodes of the next state.
      count_enable_next = (state_next == ST_COUNT);
      compare_done_next = (state_next == ST_DONE);
   end

   assign bus.count_enable  = count_enable_reg;
   assign bus.timeout_count = count_reg;
   assign bus.compare_ge    = compare_ge_reg;
   assign bus.compare_done  = compare_done_reg;
   assign bus.compare_err   = compare_err_reg;

endmodule

// File: tb/tb_freq_compare_ctrl.sv
// Directed testbench for freq_compare_ctrl: window length, stale-done
// rejection, compare results, watchdog, zero length, abort priority and
// (with FREQ_COMPARE_MARGIN_EN) the margin term.
module tb_freq_compare_ctrl;
   localparam int DW = 32;
   localparam int WL = 64;

   logic clk = 1'b0;
   logic reset_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   freq_compare_ctrl_if #(.DATA_WIDTH(DW)) bus ();

   freq_compare_ctrl #(.DATA_WIDTH(DW), .WAIT_LIMIT(WL)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts a window of the given length and counts count_enable cycles.
   task automatic open_window(input logic [DW-1:0] value, output int cycles);
      bus.enable = 1'b0;
      tick();
      tick();
      bus.timeout_value = value;
      bus.enable = 1'b1;
      tick();
      cycles = 0;
      while (bus.count_enable === 1'b1 && cycles < 5000) begin
         cycles++;
         tick();
      end
   endtask

   task automatic run_compare(input logic [DW-1:0] value, input logic [DW-1:0] cmp,
                              input logic [DW-1:0] margin, input logic exp_ge);
      int cycles;
      bus.timer_done = 1'b0;
      bus.timeout_compare = cmp;
`ifdef FREQ_COMPARE_MARGIN_EN
      bus.margin = margin;
`endif
      open_window(value, cycles);
      n_cmp++;
      if (cycles !== int'(value)) begin
         n_bad++;
         $display("FAIL window_len: got %0d expected %0d", cycles, value);
      end
      n_cmp++;
      if (bus.timeout_count !== value) begin
         n_bad++;
         $display("FAIL timeout_count: got %0d expected %0d", bus.timeout_count, value);
      end
      repeat (4) tick();
      n_cmp++;
      if (bus.compare_done !== 1'b0) begin
         n_bad++;
         $display("FAIL done_early: got %b expected 0", bus.compare_done);
      end
      bus.timer_done = 1'b1;
      tick();
      n_cmp++;
      if (bus.compare_done !== 1'b0) begin
         n_bad++;
         $display("FAIL done_latency1: got %b expected 0", bus.compare_done);
      end
      tick();
      n_cmp++;
      if (bus.compare_done !== 1'b1 || bus.compare_ge !== exp_ge || bus.compare_err !== 1'b0) begin
         n_bad++;
         $display("FAIL result: done=%b ge=%b err=%b expected done=1 ge=%b err=0",
                  bus.compare_done, bus.compare_ge, bus.compare_err, exp_ge);
      end
      repeat (3) tick();
      n_cmp++;
      if (bus.compare_done !== 1'b1 || bus.count_enable !== 1'b0) begin
         n_bad++;
         $display("FAIL done_hold: done=%b ce=%b expected done=1 ce=0",
                  bus.compare_done, bus.count_enable);
      end
      bus.timer_done = 1'b0;
      bus.enable = 1'b0;
      tick();
      n_cmp++;
      if (bus.compare_done !== 1'b0 || bus.compare_ge !== exp_ge) begin
         n_bad++;
         $display("FAIL clear: done=%b ge=%b expected done=0 ge=%b",
                  bus.compare_done, bus.compare_ge, exp_ge);
      end
      $display("run value=%0d compare=%0d margin=%0d window=%0d ge=%b", value, cmp, margin, cycles, bus.compare_ge);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus.enable = 1'b0;
      bus.timeout_value = '0;
      bus.timer_done = 1'b0;
      bus.timeout_compare = '0;
`ifdef FREQ_COMPARE_MARGIN_EN
      bus.margin = '0;
`endif
      repeat (3) tick();
      n_cmp++;
      if ({bus.count_enable, bus.compare_done, bus.compare_err, bus.compare_ge} !== 4'b0 || bus.timeout_count !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: ce/done/err/ge=%b%b%b%b count=%0d expected all 0",
                  bus.count_enable, bus.compare_done, bus.compare_err, bus.compare_ge, bus.timeout_count);
      end
      reset_n = 1'b1;
      tick();
      bus.timeout_value = 100;
      bus.enable = 1'b1;
      tick();
      repeat (20) tick();
      n_cmp++;
      if (bus.count_enable !== 1'b1 || bus.timeout_count !== 32'd20) begin
         n_bad++;
         $display("FAIL mid_count: ce=%b count=%0d expected ce=1 count=20", bus.count_enable, bus.timeout_count);
      end
      reset_n = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if ({bus.count_enable, bus.compare_done, bus.compare_err, bus.compare_ge} !== 4'b0 || bus.timeout_count !== '0) begin
         n_bad++;
         $display("FAIL reset_mid_count: ce/done/err/ge=%b%b%b%b count=%0d expected all 0",
                  bus.count_enable, bus.compare_done, bus.compare_err, bus.compare_ge, bus.timeout_count);
      end
      bus.enable = 1'b0;
      reset_n = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if (bus.count_enable !== 1'b0 || bus.compare_done !== 1'b0) begin
         n_bad++;
         $display("FAIL post_reset_idle: ce=%b done=%b expected 0 0", bus.count_enable, bus.compare_done);
      end
      $display("reset test done");
   endtask

   task automatic test_normal();
      run_compare(100, 150, 0, 1'b1);
   endtask

   task automatic test_slow();
      run_compare(100, 60, 0, 1'b0);
   endtask

   task automatic test_boundary();
      run_compare(100, 99, 0, 1'b0);
      run_compare(100, 100, 0, 1'b1);
   endtask

   task automatic test_stale_done();
      int cycles;
      // Old done held high until cycle 120 of the window.
      bus.timer_done = 1'b1;
      bus.timeout_compare = 130;
      bus.enable = 1'b0;
      tick();
      tick();
      bus.timeout_value = 100;
      bus.enable = 1'b1;
      tick();
      cycles = 0;
      while (bus.count_enable === 1'b1 && cycles < 5000) begin
         cycles++;
         if (cycles == 120) bus.timer_done = 1'b0;
         tick();
      end
      n_cmp++;
      if (cycles !== 120 || bus.timeout_count !== 32'd120) begin
         n_bad++;
         $display("FAIL stale_window: window=%0d count=%0d expected 120 120", cycles, bus.timeout_count);
      end
      repeat (3) tick();
      n_cmp++;
      if (bus.compare_done !== 1'b0) begin
         n_bad++;
         $display("FAIL stale_no_done: got %b expected 0", bus.compare_done);
      end
      bus.timer_done = 1'b1;
      tick();
      tick();
      n_cmp++;
      if (bus.compare_done !== 1'b1 || bus.compare_ge !== 1'b1) begin
         n_bad++;
         $display("FAIL stale_result: done=%b ge=%b expected 1 1", bus.compare_done, bus.compare_ge);
      end
      $display("stale run window=%0d count=%0d ge=%b", cycles, bus.timeout_count, bus.compare_ge);

      // Done drops at cycle 10 and rises again at 20: window ends on time.
      bus.timeout_compare = 60;
      bus.enable = 1'b0;
      tick();
      tick();
      bus.timeout_value = 50;
      bus.enable = 1'b1;
      tick();
      cycles = 0;
      while (bus.count_enable === 1'b1 && cycles < 5000) begin
         cycles++;
         if (cycles == 10) bus.timer_done = 1'b0;
         if (cycles == 20) bus.timer_done = 1'b1;
         tick();
      end
      n_cmp++;
      if (cycles !== 50) begin
         n_bad++;
         $display("FAIL cleared_window: got %0d expected 50", cycles);
      end
      tick();
      tick();
      n_cmp++;
      if (bus.compare_done !== 1'b1 || bus.compare_ge !== 1'b1) begin
         n_bad++;
         $display("FAIL cleared_result: done=%b ge=%b expected 1 1", bus.compare_done, bus.compare_ge);
      end
      bus.timer_done = 1'b0;
      bus.enable = 1'b0;
      tick();
      $display("redone run window=%0d ge=%b", cycles, bus.compare_ge);
   endtask

   task automatic test_watchdog();
      int cycles;
      int w;
      bus.timer_done = 1'b0;
      open_window(10, cycles);
      w = 0;
      while (bus.compare_done !== 1'b1 && w < 500) begin
         tick();
         w++;
      end
      n_cmp++;
      if (cycles !== 10 || w !== WL) begin
         n_bad++;
         $display("FAIL watchdog_time: window=%0d wait=%0d expected 10 %0d", cycles, w, WL);
      end
      n_cmp++;
      if (bus.compare_err !== 1'b1 || bus.compare_ge !== 1'b0) begin
         n_bad++;
         $display("FAIL watchdog_flags: err=%b ge=%b expected 1 0", bus.compare_err, bus.compare_ge);
      end
      bus.enable = 1'b0;
      tick();
      n_cmp++;
      if (bus.compare_err !== 1'b0 || bus.compare_done !== 1'b0) begin
         n_bad++;
         $display("FAIL watchdog_clear: err=%b done=%b expected 0 0", bus.compare_err, bus.compare_done);
      end
      $display("watchdog run wait=%0d", w);
   endtask

   task automatic test_zero_value();
      int ce_seen;
      run_compare(5, 9, 0, 1'b1);
      bus.timeout_value = 0;
      bus.enable = 1'b1;
      tick();
      n_cmp++;
      if (bus.compare_done !== 1'b1 || bus.compare_err !== 1'b1 || bus.compare_ge !== 1'b0) begin
         n_bad++;
         $display("FAIL zero_value: done=%b err=%b ge=%b expected 1 1 0",
                  bus.compare_done, bus.compare_err, bus.compare_ge);
      end
      ce_seen = 0;
      for (int i = 0; i < 5; i++) begin
         if (bus.count_enable === 1'b1) ce_seen++;
         tick();
      end
      n_cmp++;
      if (ce_seen !== 0) begin
         n_bad++;
         $display("FAIL zero_no_window: got %0d window cycles expected 0", ce_seen);
      end
      bus.enable = 1'b0;
      tick();
      $display("zero value run err=%b", bus.compare_err);
   endtask

   task automatic test_abort();
      int cycles;
      bus.timer_done = 1'b0;
      bus.timeout_value = 100;
      bus.enable = 1'b1;
      tick();
      repeat (10) tick();
      bus.enable = 1'b0;
      tick();
      n_cmp++;
      if (bus.count_enable !== 1'b0 || bus.compare_done !== 1'b0 || bus.timeout_count !== 32'd10) begin
         n_bad++;
         $display("FAIL abort_count: ce=%b done=%b count=%0d expected 0 0 10",
                  bus.count_enable, bus.compare_done, bus.timeout_count);
      end
      tick();
      n_cmp++;
      if (bus.timeout_count !== 32'd10) begin
         n_bad++;
         $display("FAIL abort_hold: count=%0d expected 10", bus.timeout_count);
      end

      // Abort and timer_done in the same cycle.
      open_window(8, cycles);
      bus.enable = 1'b0;
      bus.timer_done = 1'b1;
      tick();
      tick();
      n_cmp++;
      if (bus.compare_done !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_vs_done: done=%b expected 0", bus.compare_done);
      end
      bus.timer_done = 1'b0;

      // Abort and watchdog expiry in the same cycle.
      open_window(8, cycles);
      repeat (WL - 1) tick();
      bus.enable = 1'b0;
      tick();
      tick();
      n_cmp++;
      if (bus.compare_done !== 1'b0 || bus.compare_err !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_vs_watchdog: done=%b err=%b expected 0 0", bus.compare_done, bus.compare_err);
      end
      $display("abort tests done");
   endtask

`ifdef FREQ_COMPARE_MARGIN_EN
   task automatic test_margin();
      run_compare(100, 95, 5, 1'b1);
      run_compare(100, 94, 5, 1'b0);
   endtask
`endif

   initial begin
      test_reset();
      test_normal();
      test_slow();
      test_boundary();
      test_stale_done();
      test_watchdog();
      test_zero_value();
      test_abort();
`ifdef FREQ_COMPARE_MARGIN_EN
      test_margin();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
